// File: rtl/mmio_timer_intr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmio_timer_intr : IOBUS-mapped interval timer with prescaler, one-shot /
//                   periodic modes and a single-cycle interrupt pulse.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module mmio_timer_intr #(
  parameter logic [31:0] BASE_AD = 32'h11100000,
  parameter int          PRE_W   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_RD,
  output logic        IOBUS_HIT,
  output logic        INTR
);

  localparam logic [31:0] C_AD_CTRL = BASE_AD;
  localparam logic [31:0] C_AD_TC   = BASE_AD + 32'h4;
  localparam logic [31:0] C_AD_CNT  = BASE_AD + 32'h8;
  localparam logic [31:0] C_AD_STAT = BASE_AD + 32'hC;

  logic             en_q,   en_d;
  logic             auto_q, auto_d;
  logic [PRE_W-1:0] div_q,  div_d;
  logic [PRE_W-1:0] pre_q,  pre_d;
  logic [31:0]      tc_q,   tc_d;
  logic [31:0]      cnt_q,  cnt_d;
  logic             pend_q, pend_d;
  logic             intr_q, intr_d;

  logic w_sel_ctrl, w_sel_tc, w_sel_cnt, w_sel_stat;
  logic w_wr_ctrl, w_wr_tc, w_wr_stat;
  logic w_tick, w_term, w_cancel, w_term_eff;
  logic w_restart, w_freeze;

  assign w_sel_ctrl = (IOBUS_ADDR == C_AD_CTRL);
  assign w_sel_tc   = (IOBUS_ADDR == C_AD_TC);
  assign w_sel_cnt  = (IOBUS_ADDR == C_AD_CNT);
  assign w_sel_stat = (IOBUS_ADDR == C_AD_STAT);

  assign w_wr_ctrl  = IOBUS_WR && w_sel_ctrl;
  assign w_wr_tc    = IOBUS_WR && w_sel_tc;
  assign w_wr_stat  = IOBUS_WR && w_sel_stat;

  // ">=" rather than "==" so a DIV lowered below the running prescaler
  // value wraps on the next cycle instead of running through 2^PRE_W.
  assign w_tick     = en_q && (pre_q >= div_q);
  assign w_term     = w_tick && (cnt_q == tc_q);

  // A TC write or a disabling CTRL write overrides a coincident terminal event.
  assign w_cancel   = w_wr_tc || (w_wr_ctrl && !IOBUS_OUT[0]);
  assign w_term_eff = w_term && !w_cancel;
  assign w_restart  = w_wr_tc || (w_wr_ctrl && IOBUS_OUT[0] && !en_q);
  assign w_freeze   = w_wr_ctrl && !IOBUS_OUT[0];

  always_comb begin
    en_d   = en_q;
    auto_d = auto_q;
    div_d  = div_q;
    pre_d  = pre_q;
    tc_d   = tc_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    intr_d = 1'b0;

    if (en_q) begin
      if (w_tick) begin
        pre_d = '0;
        cnt_d = w_term ? 32'd0 : cnt_q + 32'd1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    if (w_wr_ctrl) begin
      auto_d = IOBUS_OUT[1];
      div_d  = IOBUS_OUT[PRE_W+7:8];
      en_d   = IOBUS_OUT[0] && !(w_term_eff && !IOBUS_OUT[1]);
    end else if (w_term_eff && !auto_q) begin
      en_d = 1'b0;
    end

    if (w_wr_tc) begin
      tc_d = IOBUS_OUT;
    end

    if (w_restart) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (w_freeze) begin
      cnt_d = cnt_q;
      pre_d = pre_q;
    end

    // Set wins over a simultaneous W1C.
    pend_d = (pend_q && !(w_wr_stat && IOBUS_OUT[0])) || w_term_eff;
    intr_d = w_term_eff;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_q   <= 1'b0;
      auto_q <= 1'b0;
      div_q  <= '0;
      pre_q  <= '0;
      tc_q   <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      auto_q <= auto_d;
      div_q  <= div_d;
      pre_q  <= pre_d;
      tc_q   <= tc_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      intr_q <= intr_d;
    end
  end

  always_comb begin
    IOBUS_RD  = '0;
    IOBUS_HIT = 1'b0;
    if (w_sel_ctrl) begin
      IOBUS_HIT            = 1'b1;
      IOBUS_RD[0]          = en_q;
      IOBUS_RD[1]          = auto_q;
      IOBUS_RD[PRE_W+7:8]  = div_q;
    end else if (w_sel_tc) begin
      IOBUS_HIT = 1'b1;
      IOBUS_RD  = tc_q;
    end else if (w_sel_cnt) begin
      IOBUS_HIT = 1'b1;
      IOBUS_RD  = cnt_q;
    end else if (w_sel_stat) begin
      IOBUS_HIT   = 1'b1;
      IOBUS_RD[0] = pend_q;
    end
  end

  assign INTR = intr_q;

endmodule
`default_nettype wire

// File: doc/mmio_timer_intr.md
Name: mmio_timer_intr

Overview:
Memory-mapped programmable interval timer on the OTTER IOBUS. It sits beside the switch/LED/7-seg peripherals in the top-level wrapper and drives the MCU interrupt input, replacing the button one-shot as the interrupt source. Firmware programs the period and mode through IOBUS writes and reads status and count back through the wrapper's input mux.

Parameters:
BASE_AD, 32'h11100000, base address of the 4-word register block
PRE_W, 8, prescaler divisor width

Ports:
CLK  in  1  system clock (the divided MCU clock)
RST_N  in  1  asynchronous active-low reset
IOBUS_ADDR  in  32  MCU bus address
IOBUS_OUT  in  32  MCU write data
IOBUS_WR  in  1  MCU write strobe, one cycle per store
IOBUS_RD  out  32  read data for the wrapper input mux; combinational
IOBUS_HIT  out  1  high when IOBUS_ADDR matches any register in this block
INTR  out  1  interrupt pulse to the MCU, one CLK cycle wide

Behaviour:
Register map (word addresses, exact match only):
- BASE+0 CTRL (R/W): [0] EN, [1] AUTO (1 = periodic, 0 = one-shot), [PRE_W+7:8] DIV; other bits read 0.
- BASE+4 TC (R/W): 32-bit terminal count.
- BASE+8 CNT (R only): current count. Writes are ignored.
- BASE+C STAT (R/W1C): [0] PEND, sticky. Writing 1 to bit0 clears PEND.
Reset: all registers, the prescaler, CNT, PEND and INTR are 0. IOBUS_HIT and IOBUS_RD are combinational from the address.
Prescaler:
- Counts 0..DIV every cycle while EN=1.
- Generates TICK on the cycle the prescaler equals DIV, then wraps to 0.
- DIV=0 produces TICK every cycle.
Counter:
- On TICK, CNT increments.
- When CNT==TC on a TICK (terminal event):
  - CNT returns to 0 and the prescaler returns to 0.
  - PEND is set.
  - INTR is 1 for exactly the next cycle.
  - If AUTO=0, EN clears in the same cycle.
- First interrupt latency after EN rises: (TC+1)*(DIV+1) cycles. Periodic spacing is the same value.
- TC==0: a terminal event fires on every TICK.
Disable:
- EN=0 freezes the prescaler and CNT and holds their values.
- Re-enabling resumes from the held values.
Write side effects:
- A write to TC clears CNT and the prescaler.
- A write to CTRL with EN transitioning 0->1 clears CNT and the prescaler.
- A write to CTRL with EN already 1 updates AUTO/DIV only; counting continues.
Simultaneous events:
- CTRL write with EN=0 in the same cycle as a terminal event: the write wins. No INTR, PEND unchanged, CNT holds.
- TC write in the same cycle as a terminal event: the write wins. CNT is cleared, no INTR.
- STAT W1C in the same cycle as a terminal event: PEND stays set (set wins); INTR still pulses.
Bus decoding:
- Writes to non-matching addresses are ignored.
- IOBUS_RD is 0 when IOBUS_HIT=0.
Reset mid-count: RST_N low at any time asynchronously zeroes all state. INTR drops immediately.

Test Plan:
- Reset: RST_N low with EN previously 1 and CNT=5 -> CNT, CTRL, TC, PEND, INTR all read 0 and INTR=0 within the same cycle; IOBUS_RD=0 for an unmapped address.
- One-shot: TC=3, DIV=1, write CTRL=0x101 (EN=1, AUTO=0, DIV=1) -> INTR single pulse 8 cycles after the write; EN reads 0 afterwards; PEND=1; no further pulses over 50 cycles.
- Periodic: TC=2, DIV=0, AUTO=1, EN=1 -> INTR pulses every 3 cycles. Write STAT=1 -> PEND clears; PEND sets again on the next pulse.
- Write collisions:
  - Disable write on the terminal-event cycle -> no INTR, CNT holds its value.
  - W1C on the terminal-event cycle -> PEND remains 1 and INTR pulses.
- Reprogram on the fly: while running with TC=10, CNT=7, write TC=4 -> CNT reads 0 next cycle; next INTR 5*(DIV+1) cycles later.
- Decode: write 0xFFFFFFFF to BASE+8 and to BASE+0x10 -> CNT unaffected, IOBUS_HIT=0 at BASE+0x10, no register changes.
